eth_pcs_rx_sync: RTL
====================

# eth_pcs_rx_sync

Block-synchronisation and BER-monitor controller for the 10GBASE-R PCS receive path. It sits between the RX gearbox and the descrambler/66b-64b decoder. It qualifies each received 2-bit sync header, runs a parametrised Clause-49-style block-lock state machine, and issues single-cycle slip requests to the gearbox until lock is achieved. While locked, it tracks the sync-header error rate and reports a high-BER condition, so downstream logic can discard blocks received without lock or at high BER.

## Interface

Parameters
- `LOCK_CNT`, 64: consecutive valid headers required to declare lock; also the length of the locked error-test window.
- `SH_INVLD_MAX`, 16: number of invalid headers within one `LOCK_CNT` window that drops lock.
- `SLIP_WAIT`, 8: `i_clk` cycles after a slip during which headers are ignored.
- `BER_WINDOW`, 19531: BER timer period in `i_clk` cycles (125 µs at 156.25 MHz).
- `BER_MAX`, 16: invalid headers within one BER window that set hi-BER.
- `W_BER_CNT`, 6: width of the saturating error counter.

Ports
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_clk_en`, in, 1: gearbox data valid; a header is evaluated only when this is high.
- `i_grbx_hdr_valid`, in, 1: the gearbox header field is meaningful this cycle.
- `i_grbx_hdr`, in, 2: received sync header.
- `o_slip`, out, 1: one-cycle bit-slip request to the gearbox.
- `o_block_lock`, out, 1: block lock achieved.
- `o_hi_ber`, out, 1: high bit-error rate detected.
- `o_sh_err`, out, 1: one-cycle pulse for each evaluated invalid header.
- `o_ber_cnt`, out, `W_BER_CNT`: saturating count of invalid headers seen while locked.

## Operation

- An evaluation event occurs when `i_clk_en && i_grbx_hdr_valid` is high and the FSM is not in SLIP.
- A header is valid when `i_grbx_hdr` is `2'b01` or `2'b10`; `00` and `11` are invalid.
- Counters:
  - `sh_cnt` counts from 0 to `LOCK_CNT`.
  - `sh_invld_cnt` counts from 0 to `SH_INVLD_MAX`.
  - `slip_cnt` counts from 0 to `SLIP_WAIT-1`.
- HUNT (the reset state; `o_block_lock`=0):
  - On a valid event, increment `sh_cnt`. When the increment reaches `LOCK_CNT`, go to LOCKED and clear the counters.
  - On an invalid event, go to SLIP.
- LOCKED (`o_block_lock`=1):
  - Every event increments `sh_cnt`; an invalid event also increments `sh_invld_cnt`.
  - If `sh_invld_cnt` reaches `SH_INVLD_MAX`, go to SLIP.
  - Otherwise, when `sh_cnt` reaches `LOCK_CNT`, clear both counters and stay in LOCKED.
  - SLIP takes priority when both conditions occur on the same event.
- SLIP (`o_block_lock`=0):
  - `o_slip`=1 in the first SLIP cycle only.
  - Headers are ignored; `o_sh_err` is still not generated.
  - After `SLIP_WAIT` cycles in SLIP (independent of `i_clk_en`), go to HUNT with all counters cleared.
- BER monitor (active only while `o_block_lock`=1):
  - Free-running `ber_timer` counts from 0 to `BER_WINDOW-1` and wraps.
  - `ber_hits` counts invalid events.
  - When `ber_hits` reaches `BER_MAX`, set `o_hi_ber`=1.
  - At timer wrap: if `ber_hits` < `BER_MAX`, clear `o_hi_ber`; clear `ber_hits` in either case.
  - If a hit reaching `BER_MAX` coincides with the wrap, `o_hi_ber`=1 wins and `ber_hits` clears.
  - While `o_block_lock`=0: `ber_timer`, `ber_hits` and `o_hi_ber` are held at 0.
- `o_ber_cnt` increments on each invalid event while locked and saturates at 2^`W_BER_CNT`-1. Only reset clears it.
- `o_sh_err` pulses on every invalid evaluation event, in HUNT or in LOCKED.

## Timing

- All outputs are registered.
- A decision made on an event in cycle N is visible at the outputs in cycle N+1. This applies to `o_block_lock`, `o_slip`, `o_sh_err`, `o_hi_ber` and `o_ber_cnt`.
- Reset values: all outputs are 0. The FSM is in HUNT, and all counters and the BER timer are 0.
- Asserting `i_reset` at any point, including mid-SLIP or while locked, immediately forces the reset values. Operation resumes on the first clock edge after deassertion.
- Slip spacing:
  - Minimum spacing between `o_slip` pulses is `SLIP_WAIT`+1 cycles: `SLIP_WAIT` cycles in SLIP, plus at least one HUNT event.
  - The SLIP-to-HUNT transition occurs at the end of cycle `SLIP_WAIT` counted from SLIP entry.
  - In HUNT, a header present in the first HUNT cycle is evaluated.
- Fastest lock: `LOCK_CNT` back-to-back valid events give `o_block_lock`=1 one cycle after the last event.
- Events arriving with `i_clk_en`=0 or `i_grbx_hdr_valid`=0 are ignored and do not advance `sh_cnt`.

## Test plan

- Reset, then 64 consecutive valid headers (`01`/`10` alternating) → `o_block_lock` rises the cycle after the 64th; `o_slip`, `o_sh_err` and `o_hi_ber` stay 0.
- In HUNT, an invalid header `11` on event 10 → `o_sh_err` and `o_slip` each pulse for 1 cycle. Headers over the next 8 cycles are ignored. Lock then needs 64 new valid events.
- Locked, 15 invalid headers within a 64-event window → lock held and `o_ber_cnt`=15. A 16th invalid header within one window → lock drops and `o_slip` pulses the next cycle.
- BER_WINDOW=2000, locked, one invalid header every 100 events → `o_hi_ber`=1 the cycle after the 16th hit. A following window with 0 hits → `o_hi_ber`=0 the cycle after the wrap.
- Locked, 70 invalid headers spaced to avoid lock loss (≤15 per 64 events) → `o_ber_cnt` saturates at 63.
- Assert `i_reset` in the 3rd SLIP cycle → all outputs 0 immediately. After release, 64 valid events → lock.

Source files
------------

// File: rtl/eth_pcs_rx_sync.sv
// rtl/eth_pcs_rx_sync.sv - 10GBASE-R RX block lock, gearbox slip control and BER monitor
module eth_pcs_rx_sync #(
  parameter int LOCK_CNT     = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 8,
  parameter int BER_WINDOW   = 19531,
  parameter int BER_MAX      = 16,
  parameter int W_BER_CNT    = 6
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clk_en,
  input  logic                 i_grbx_hdr_valid,
  input  logic [1:0]           i_grbx_hdr,
  output logic                 o_slip,
  output logic                 o_block_lock,
  output logic                 o_hi_ber,
  output logic                 o_sh_err,
  output logic [W_BER_CNT-1:0] o_ber_cnt
);

  localparam int SH_W   = $clog2(LOCK_CNT + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);
  localparam int TMR_W  = $clog2(BER_WINDOW + 1);
  localparam int HIT_W  = $clog2(BER_MAX + 1);

  localparam logic [SH_W-1:0]      LOCK_CNT_V  = SH_W'(LOCK_CNT);
  localparam logic [INV_W-1:0]     INV_MAX_V   = INV_W'(SH_INVLD_MAX);
  localparam logic [SLIP_W-1:0]    SLIP_LAST_V = SLIP_W'(SLIP_WAIT - 1);
  localparam logic [TMR_W-1:0]     WIN_LAST_V  = TMR_W'(BER_WINDOW - 1);
  localparam logic [HIT_W-1:0]     BER_MAX_V   = HIT_W'(BER_MAX);
  localparam logic [W_BER_CNT-1:0] BER_CNT_MAX = {W_BER_CNT{1'b1}};

  typedef enum logic [1:0] {ST_HUNT, ST_LOCKED, ST_SLIP} state_t;

  state_t               state_q, state_d;
  logic [SH_W-1:0]      sh_cnt_q, sh_cnt_d, sh_inc;
  logic [INV_W-1:0]     invld_q, invld_d, invld_inc;
  logic [SLIP_W-1:0]    slip_cnt_q, slip_cnt_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [HIT_W-1:0]     hits_q, hits_d, hits_inc;
  logic                 hi_ber_q, hi_ber_d;
  logic                 slip_q, slip_d;
  logic                 lock_q, lock_d;
  logic                 sh_err_q, sh_err_d;
  logic [W_BER_CNT-1:0] ber_cnt_q, ber_cnt_d;
  logic                 hdr_ok, ev, bad_ev, ber_active;

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    invld_d    = invld_q;
    slip_cnt_d = slip_cnt_q;
    hdr_ok     = i_grbx_hdr[1] ^ i_grbx_hdr[0];
    ev         = i_clk_en & i_grbx_hdr_valid & (state_q != ST_SLIP);
    bad_ev     = ev & ~hdr_ok;
    sh_inc     = sh_cnt_q + SH_W'(1);
    invld_inc  = invld_q + INV_W'(bad_ev);

    case (state_q)
      ST_HUNT: begin
        if (bad_ev) begin
          state_d    = ST_SLIP;
          sh_cnt_d   = '0;
          slip_cnt_d = '0;
        end else if (ev) begin
          if (sh_inc == LOCK_CNT_V) begin
            state_d  = ST_LOCKED;
            sh_cnt_d = '0;
            invld_d  = '0;
          end else begin
            sh_cnt_d = sh_inc;
          end
        end
      end
      ST_LOCKED: begin
        if (ev) begin
          // Too many bad headers wins over a window rollover on the same event.
          if (invld_inc == INV_MAX_V) begin
            state_d    = ST_SLIP;
            sh_cnt_d   = '0;
            invld_d    = '0;
            slip_cnt_d = '0;
          end else if (sh_inc == LOCK_CNT_V) begin
            sh_cnt_d = '0;
            invld_d  = '0;
          end else begin
            sh_cnt_d = sh_inc;
            invld_d  = invld_inc;
          end
        end
      end
      ST_SLIP: begin
        if (slip_cnt_q == SLIP_LAST_V) begin
          state_d    = ST_HUNT;
          sh_cnt_d   = '0;
          invld_d    = '0;
          slip_cnt_d = '0;
        end else begin
          slip_cnt_d = slip_cnt_q + SLIP_W'(1);
        end
      end
      default: state_d = ST_HUNT;
    endcase

    slip_d    = (state_q != ST_SLIP) && (state_d == ST_SLIP);
    lock_d    = (state_d == ST_LOCKED);
    sh_err_d  = bad_ev;
    ber_cnt_d = ber_cnt_q;
    if (bad_ev && (state_q == ST_LOCKED) && (ber_cnt_q != BER_CNT_MAX))
      ber_cnt_d = ber_cnt_q + W_BER_CNT'(1);

    // BER state only runs across cycles that start and end locked.
    ber_active = (state_q == ST_LOCKED) && (state_d == ST_LOCKED);
    hits_inc   = (hits_q == BER_MAX_V) ? hits_q : hits_q + HIT_W'(bad_ev);
    timer_d    = '0;
    hits_d     = '0;
    hi_ber_d   = 1'b0;
    if (ber_active) begin
      if (timer_q == WIN_LAST_V) begin
        hi_ber_d = (hits_inc == BER_MAX_V);
      end else begin
        timer_d  = timer_q + TMR_W'(1);
        hits_d   = hits_inc;
        hi_ber_d = hi_ber_q | (hits_inc == BER_MAX_V);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_HUNT;
      sh_cnt_q   <= '0;
      invld_q    <= '0;
      slip_cnt_q <= '0;
      timer_q    <= '0;
      hits_q     <= '0;
      hi_ber_q   <= 1'b0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
      sh_err_q   <= 1'b0;
      ber_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      invld_q    <= invld_d;
      slip_cnt_q <= slip_cnt_d;
      timer_q    <= timer_d;
      hits_q     <= hits_d;
      hi_ber_q   <= hi_ber_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
      sh_err_q   <= sh_err_d;
      ber_cnt_q  <= ber_cnt_d;
    end
  end

  assign o_slip       = slip_q;
  assign o_block_lock = lock_q;
  assign o_hi_ber     = hi_ber_q;
  assign o_sh_err     = sh_err_q;
  assign o_ber_cnt    = ber_cnt_q;

endmodule
